ieee_adder_pipe: RTL and testbench

Parametrised, pipelined IEEE-754 add/subtract unit, generalised from the combinational single-precision adder chain.
- Format widths, guard depth and sideband tag width are parameters.
- Four-stage pipeline with valid/ready handshake on both sides and full backpressure.
- Adds correct round-to-nearest-even (guard/round/sticky), flush-to-zero of subnormals, Inf/NaN handling and exception flags.
- Sits between the operand scheduler and the result writeback in the FPU datapath.

---
 rtl/ieee_adder_pipe.sv | 278 +++++++++++++++++++++++++++
 tb/tb_ieee_adder_pipe.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ieee_adder_pipe.sv
// Four-stage pipelined IEEE-754 add/subtract with round-to-nearest-even, flush-to-zero
// of subnormals, Inf/NaN handling and {invalid, overflow, inexact, zero} flags.
module ieee_adder_pipe #(
  parameter int unsigned EXP_W   = 8,
  parameter int unsigned MAN_W   = 23,
  parameter int unsigned GUARD_W = 3,
  parameter int unsigned TAG_W   = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   in_a,
  input  logic [EXP_W+MAN_W:0]   in_b,
  input  logic                   in_sub,
  input  logic [TAG_W-1:0]       in_tag,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   out_result,
  output logic [TAG_W-1:0]       out_tag,
  output logic [3:0]             out_flags
);

  localparam int unsigned W     = 1 + EXP_W + MAN_W;
  localparam int unsigned SIG_W = 2 + MAN_W + GUARD_W;
  localparam int unsigned EXW   = EXP_W + 2;
  localparam int unsigned LZW   = $clog2(SIG_W);

  localparam logic [EXP_W-1:0]      EXP_MAX = '1;
  localparam logic signed [EXW-1:0] EXP_INF = {2'b00, EXP_MAX};
  localparam logic [W-1:0]          QNAN    = {1'b0, EXP_MAX, 1'b1, {(MAN_W-1){1'b0}}};

  logic w_en;
  assign w_en     = !out_valid || out_ready;
  assign in_ready = w_en;

  // ---------------- S1: unpack / classify / compare ----------------
  logic                   w_sa, w_sb, w_za, w_zb, w_nan_a, w_nan_b, w_inf_a, w_inf_b;
  logic [EXP_W-1:0]       w_ea, w_eb;
  logic [MAN_W-1:0]       w_fa, w_fb;
  logic [EXP_W+MAN_W-1:0] w_mag_a, w_mag_b;
  logic [SIG_W-1:0]       w_sig_a, w_sig_b;
  logic                   w_a_big;
  logic [W-1:0]           w_spec_res;
  logic                   w_invalid;

  assign w_sa    = in_a[W-1];
  assign w_sb    = in_b[W-1] ^ in_sub;
  assign w_ea    = in_a[W-2 -: EXP_W];
  assign w_eb    = in_b[W-2 -: EXP_W];
  assign w_fa    = in_a[MAN_W-1:0];
  assign w_fb    = in_b[MAN_W-1:0];
  assign w_za    = (w_ea == '0);
  assign w_zb    = (w_eb == '0);
  assign w_nan_a = (w_ea == EXP_MAX) && (w_fa != '0);
  assign w_nan_b = (w_eb == EXP_MAX) && (w_fb != '0);
  assign w_inf_a = (w_ea == EXP_MAX) && (w_fa == '0);
  assign w_inf_b = (w_eb == EXP_MAX) && (w_fb == '0);
  // Subnormals flush to zero, so their fraction must not win the magnitude compare
  assign w_mag_a = w_za ? '0 : {w_ea, w_fa};
  assign w_mag_b = w_zb ? '0 : {w_eb, w_fb};
  assign w_sig_a = w_za ? '0 : {2'b01, w_fa, {GUARD_W{1'b0}}};
  assign w_sig_b = w_zb ? '0 : {2'b01, w_fb, {GUARD_W{1'b0}}};
  assign w_a_big = (w_mag_a >= w_mag_b);

  always_comb begin
    w_spec_res = QNAN;
    w_invalid  = 1'b0;
    if (w_nan_a || w_nan_b) begin
      w_spec_res = QNAN;
    end else if (w_inf_a && w_inf_b && (w_sa != w_sb)) begin
      w_spec_res = QNAN;
      w_invalid  = 1'b1;
    end else if (w_inf_a) begin
      w_spec_res = {w_sa, EXP_MAX, {MAN_W{1'b0}}};
    end else if (w_inf_b) begin
      w_spec_res = {w_sb, EXP_MAX, {MAN_W{1'b0}}};
    end
  end

  logic                r1_valid, r1_spec, r1_invalid, r1_sign, r1_eff_sub;
  logic [TAG_W-1:0]    r1_tag;
  logic [W-1:0]        r1_spec_res;
  logic [EXP_W-1:0]    r1_exp, r1_shift;
  logic [SIG_W-1:0]    r1_sig_big, r1_sig_small;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r1_valid     <= 1'b0;
      r1_tag       <= '0;
      r1_spec      <= 1'b0;
      r1_spec_res  <= '0;
      r1_invalid   <= 1'b0;
      r1_sign      <= 1'b0;
      r1_eff_sub   <= 1'b0;
      r1_exp       <= '0;
      r1_shift     <= '0;
      r1_sig_big   <= '0;
      r1_sig_small <= '0;
    end else if (w_en) begin
      r1_valid     <= in_valid;
      r1_tag       <= in_tag;
      r1_spec      <= w_nan_a || w_nan_b || w_inf_a || w_inf_b;
      r1_spec_res  <= w_spec_res;
      r1_invalid   <= w_invalid;
      r1_sign      <= w_a_big ? w_sa : w_sb;
      r1_eff_sub   <= w_sa ^ w_sb;
      r1_exp       <= w_a_big ? w_ea : w_eb;
      r1_shift     <= w_a_big ? (w_ea - w_eb) : (w_eb - w_ea);
      r1_sig_big   <= w_a_big ? w_sig_a : w_sig_b;
      r1_sig_small <= w_a_big ? w_sig_b : w_sig_a;
    end
  end

  // ---------------- S2: align smaller operand, collapse lost bits into sticky ----------------
  logic [SIG_W-1:0] w_mask, w_aligned;
  logic             w_sticky2;

  assign w_mask    = ~({SIG_W{1'b1}} << r1_shift);
  assign w_sticky2 = |(r1_sig_small & w_mask);
  assign w_aligned = (r1_sig_small >> r1_shift) | {{(SIG_W-1){1'b0}}, w_sticky2};

  logic                r2_valid, r2_spec, r2_invalid, r2_sign, r2_eff_sub;
  logic [TAG_W-1:0]    r2_tag;
  logic [W-1:0]        r2_spec_res;
  logic [EXP_W-1:0]    r2_exp;
  logic [SIG_W-1:0]    r2_sig_big, r2_sig_small;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r2_valid     <= 1'b0;
      r2_tag       <= '0;
      r2_spec      <= 1'b0;
      r2_spec_res  <= '0;
      r2_invalid   <= 1'b0;
      r2_sign      <= 1'b0;
      r2_eff_sub   <= 1'b0;
      r2_exp       <= '0;
      r2_sig_big   <= '0;
      r2_sig_small <= '0;
    end else if (w_en) begin
      r2_valid     <= r1_valid;
      r2_tag       <= r1_tag;
      r2_spec      <= r1_spec;
      r2_spec_res  <= r1_spec_res;
      r2_invalid   <= r1_invalid;
      r2_sign      <= r1_sign;
      r2_eff_sub   <= r1_eff_sub;
      r2_exp       <= r1_exp;
      r2_sig_big   <= r1_sig_big;
      r2_sig_small <= w_aligned;
    end
  end

  // ---------------- S3: add/subtract and normalise ----------------
  logic [SIG_W-1:0]        w_sum, w_diff;
  logic [SIG_W-2:0]        w_norm3;
  logic [LZW-1:0]          w_lz;
  logic signed [EXW-1:0]   w_exp2s, w_exp3;
  logic                    w_zero3, w_flush3, w_sign3;

  assign w_sum   = r2_sig_big + r2_sig_small;
  assign w_diff  = r2_sig_big - r2_sig_small;
  assign w_exp2s = {2'b00, r2_exp};

  always_comb begin
    w_lz = '0;
    for (int i = 0; i < int'(SIG_W) - 1; i++) begin
      if (w_diff[i]) w_lz = LZW'(int'(SIG_W) - 2 - i);
    end
  end

  always_comb begin
    w_norm3  = w_sum[SIG_W-2:0];
    w_exp3   = w_exp2s;
    w_zero3  = 1'b0;
    w_flush3 = 1'b0;
    w_sign3  = r2_sign;
    if (!r2_eff_sub) begin
      w_zero3 = (w_sum == '0);
      if (w_sum[SIG_W-1]) begin
        w_norm3 = {w_sum[SIG_W-1:2], w_sum[1] | w_sum[0]};
        w_exp3  = w_exp2s + EXW'(1);
      end
    end else begin
      w_zero3 = (w_diff == '0);
      w_norm3 = w_diff[SIG_W-2:0] << w_lz;
      w_exp3  = w_exp2s - EXW'(w_lz);
    end
    // Exact zero keeps the common sign only when both operands agree; otherwise +0
    if (w_zero3) begin
      w_sign3 = r2_eff_sub ? 1'b0 : r2_sign;
    end else if (w_exp3 <= 0) begin
      w_flush3 = 1'b1;
    end
  end

  logic                  r3_valid, r3_spec, r3_invalid, r3_sign, r3_zero, r3_flush;
  logic [TAG_W-1:0]      r3_tag;
  logic [W-1:0]          r3_spec_res;
  logic signed [EXW-1:0] r3_exp;
  logic [SIG_W-2:0]      r3_sig;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r3_valid    <= 1'b0;
      r3_tag      <= '0;
      r3_spec     <= 1'b0;
      r3_spec_res <= '0;
      r3_invalid  <= 1'b0;
      r3_sign     <= 1'b0;
      r3_zero     <= 1'b0;
      r3_flush    <= 1'b0;
      r3_exp      <= '0;
      r3_sig      <= '0;
    end else if (w_en) begin
      r3_valid    <= r2_valid;
      r3_tag      <= r2_tag;
      r3_spec     <= r2_spec;
      r3_spec_res <= r2_spec_res;
      r3_invalid  <= r2_invalid;
      r3_sign     <= w_sign3;
      r3_zero     <= w_zero3 || w_flush3;
      r3_flush    <= w_flush3;
      r3_exp      <= w_exp3;
      r3_sig      <= w_norm3;
    end
  end

  // ---------------- S4: round to nearest even and pack ----------------
  logic                  w_g, w_rs, w_rup, w_inexact4;
  logic [MAN_W+1:0]      w_mant;
  logic [MAN_W-1:0]      w_frac4;
  logic signed [EXW-1:0] w_exp4;
  logic [W-1:0]          w_res;
  logic [3:0]            w_flags;

  assign w_g        = r3_sig[GUARD_W-1];
  assign w_rs       = |r3_sig[GUARD_W-2:0];
  assign w_rup      = w_g && (w_rs || r3_sig[GUARD_W]);
  assign w_inexact4 = w_g || w_rs;
  assign w_mant     = {1'b0, r3_sig[SIG_W-2:GUARD_W]} + (MAN_W+2)'(w_rup);
  assign w_exp4     = r3_exp + EXW'(w_mant[MAN_W+1]);
  assign w_frac4    = w_mant[MAN_W+1] ? w_mant[MAN_W:1] : w_mant[MAN_W-1:0];

  always_comb begin
    w_res   = '0;
    w_flags = 4'b0000;
    if (r3_spec) begin
      w_res   = r3_spec_res;
      w_flags = {r3_invalid, 3'b000};
    end else if (r3_zero) begin
      w_res   = {r3_sign, {(W-1){1'b0}}};
      w_flags = {2'b00, r3_flush, 1'b1};
    end else if (w_exp4 >= EXP_INF) begin
      w_res   = {r3_sign, EXP_MAX, {MAN_W{1'b0}}};
      w_flags = 4'b0110;
    end else begin
      w_res   = {r3_sign, w_exp4[EXP_W-1:0], w_frac4};
      w_flags = {2'b00, w_inexact4, 1'b0};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_result <= '0;
      out_tag    <= '0;
      out_flags  <= 4'b0000;
    end else if (w_en) begin
      out_valid  <= r3_valid;
      out_result <= w_res;
      out_tag    <= r3_tag;
      out_flags  <= w_flags;
    end
  end

endmodule

// File: tb/tb_ieee_adder_pipe.sv
// Scoreboard bench for ieee_adder_pipe: directed vectors, backpressure stream,
// mid-flight reset and a double-precision instance.
module tb_ieee_adder_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in_valid, in_ready, in_sub, out_valid, out_ready;
  logic [31:0] in_a, in_b, out_result;
  logic [3:0]  in_tag, out_tag, out_flags;

  logic        d_in_valid, d_in_ready, d_in_sub, d_out_valid, d_out_ready;
  logic [63:0] d_in_a, d_in_b, d_out_result;
  logic [3:0]  d_in_tag, d_out_tag, d_out_flags;

  ieee_adder_pipe #(.EXP_W(8), .MAN_W(23), .GUARD_W(3), .TAG_W(4)) u_sp (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_tag(out_tag), .out_flags(out_flags)
  );

  ieee_adder_pipe #(.EXP_W(11), .MAN_W(52), .GUARD_W(3), .TAG_W(4)) u_dp (
    .clk(clk), .rst(rst), .in_valid(d_in_valid), .in_ready(d_in_ready),
    .in_a(d_in_a), .in_b(d_in_b), .in_sub(d_in_sub), .in_tag(d_in_tag),
    .out_valid(d_out_valid), .out_ready(d_out_ready), .out_result(d_out_result),
    .out_tag(d_out_tag), .out_flags(d_out_flags)
  );

  typedef struct packed {
    logic [31:0] res;
    logic [3:0]  flags;
    logic [3:0]  tag;
  } exp_t;

  exp_t        sb_q[$];
  logic [63:0] q64[$];
  int          checks = 0;
  int          failures = 0;

  localparam int NV = 15;
  localparam logic [31:0] VA [NV] = '{
    32'h3F800000, 32'h40400000, 32'h80000000, 32'h3F800000, 32'h3F800001,
    32'h3F800000, 32'h7F7FFFFF, 32'h7F800000, 32'h7FC00123, 32'h3F800000,
    32'h00800000, 32'hFF800000, 32'h00000001, 32'h00000000, 32'h40000000};
  localparam logic [31:0] VB [NV] = '{
    32'h40000000, 32'h40400000, 32'h80000000, 32'h33800000, 32'h33800000,
    32'h33800001, 32'h7F7FFFFF, 32'h7F800000, 32'h3F800000, 32'h3F400000,
    32'h00800001, 32'h3F800000, 32'h00000001, 32'h80000000, 32'h3F800000};
  localparam logic VS [NV] = '{
    1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1,
    1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
  localparam logic [31:0] VR [NV] = '{
    32'h40400000, 32'h00000000, 32'h80000000, 32'h3F800000, 32'h3F800002,
    32'h3F800001, 32'h7F800000, 32'h7FC00000, 32'h7FC00000, 32'h3E800000,
    32'h80000000, 32'hFF800000, 32'h00000000, 32'h00000000, 32'h3F800000};
  localparam logic [3:0] VF [NV] = '{
    4'b0000, 4'b0001, 4'b0001, 4'b0010, 4'b0010,
    4'b0010, 4'b0110, 4'b1000, 4'b0000, 4'b0000,
    4'b0011, 4'b0000, 4'b0001, 4'b0001, 4'b0000};

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %h, expected %h", name, got, want);
    end
  endtask

  // Call at posedge+#1; returns at posedge+#1 after the accepting edge
  task automatic issue(input int i, input logic [3:0] tag);
    logic got;
    got      = 1'b0;
    in_a     = VA[i];
    in_b     = VB[i];
    in_sub   = VS[i];
    in_tag   = tag;
    in_valid = 1'b1;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      got = in_ready;
      if (got) sb_q.push_back('{res: VR[i], flags: VF[i], tag: tag});
      @(posedge clk);
      #1;
      if (got) break;
    end
    in_valid = 1'b0;
    chk($sformatf("issue_accept_tag%0d", tag), 64'(got), 64'd1);
  endtask

  task automatic drain(input string name);
    for (int n = 0; n < 60; n++) begin
      if (sb_q.size() == 0) break;
      @(posedge clk);
    end
    #1;
    chk(name, 64'(sb_q.size()), 64'd0);
  endtask

  // Output monitor: pops the scoreboard on each transfer and checks hold during stalls
  initial begin
    exp_t        e;
    logic        stall_prev;
    logic [31:0] p_res;
    logic [3:0]  p_tag, p_flags;
    stall_prev = 1'b0;
    p_res = '0; p_tag = '0; p_flags = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall_prev = 1'b0;
      end else begin
        if (stall_prev) begin
          chk("hold_valid", 64'(out_valid), 64'd1);
          chk($sformatf("hold_result_tag%0d", p_tag), 64'(out_result), 64'(p_res));
          chk($sformatf("hold_tag_tag%0d", p_tag), 64'(out_tag), 64'(p_tag));
          chk($sformatf("hold_flags_tag%0d", p_tag), 64'(out_flags), 64'(p_flags));
        end
        if (out_valid) begin
          if (out_ready) begin
            if (sb_q.size() == 0) begin
              checks++;
              failures++;
              $display("FAIL unexpected_output: got result %h tag %0d, expected none", out_result, out_tag);
            end else begin
              e = sb_q.pop_front();
              chk($sformatf("result_tag%0d", e.tag), 64'(out_result), 64'(e.res));
              chk($sformatf("flags_tag%0d", e.tag), 64'(out_flags), 64'(e.flags));
              chk("tag_order", 64'(out_tag), 64'(e.tag));
            end
          end
          stall_prev = !out_ready;
          p_res   = out_result;
          p_tag   = out_tag;
          p_flags = out_flags;
        end else begin
          stall_prev = 1'b0;
        end
      end
    end
  end

  initial begin
    logic [63:0] w;
    forever begin
      @(negedge clk);
      if (!rst && d_out_valid) begin
        if (q64.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL dp_unexpected_output: got %h, expected none", d_out_result);
        end else begin
          w = q64.pop_front();
          chk("dp_result", d_out_result, w);
          chk("dp_flags", 64'(d_out_flags), 64'd0);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int  lat, idx, cnt;
    logic acc;
    rst = 1'b1;
    in_valid = 1'b0; in_a = '0; in_b = '0; in_sub = 1'b0; in_tag = '0; out_ready = 1'b1;
    d_in_valid = 1'b0; d_in_a = '0; d_in_b = '0; d_in_sub = 1'b0; d_in_tag = '0; d_out_ready = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_out_result", 64'(out_result), 64'd0);
    chk("reset_out_tag", 64'(out_tag), 64'd0);
    chk("reset_out_flags", 64'(out_flags), 64'd0);
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("no_pulse_after_reset", 64'(out_valid), 64'd0);
    end

    // Latency of a single operation through an empty pipe
    @(posedge clk);
    #1;
    in_a = VA[0]; in_b = VB[0]; in_sub = VS[0]; in_tag = 4'hF; in_valid = 1'b1;
    @(negedge clk);
    acc = in_ready;
    chk("accept_idle", 64'(acc), 64'd1);
    if (acc) sb_q.push_back('{res: VR[0], flags: VF[0], tag: 4'hF});
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 1;
    while (lat < 20) begin
      @(negedge clk);
      if (out_valid) break;
      @(posedge clk);
      lat++;
    end
    chk("latency", 64'(lat), 64'd4);
    @(posedge clk);
    #1;

    // Directed vectors back to back
    for (int i = 0; i < NV; i++) issue(i, 4'(i));
    drain("drain_directed");

    // Eight-op stream with output stalled on cycles 6..9
    idx = 0;
    for (int k = 0; k < 30 && idx < 8; k++) begin
      out_ready = !(k >= 6 && k <= 9);
      in_a = VA[idx]; in_b = VB[idx]; in_sub = VS[idx]; in_tag = 4'(idx); in_valid = 1'b1;
      @(negedge clk);
      if (k >= 6 && k <= 9) chk($sformatf("in_ready_stall_c%0d", k), 64'(in_ready), 64'd0);
      if (in_ready) begin
        sb_q.push_back('{res: VR[idx], flags: VF[idx], tag: 4'(idx)});
        idx++;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("stream_accepted", 64'(idx), 64'd8);
    drain("drain_stream");

    // Reset with three operations in flight (first one held at the output)
    out_ready = 1'b0;
    issue(0, 4'd8);
    issue(3, 4'd9);
    issue(6, 4'd10);
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (out_valid) break;
    end
    chk("rst_setup_valid", 64'(out_valid), 64'd1);
    #1 rst = 1'b1;
    sb_q.delete();
    #1;
    chk("rst_async_valid", 64'(out_valid), 64'd0);
    chk("rst_async_result", 64'(out_result), 64'd0);
    chk("rst_async_tag", 64'(out_tag), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    out_ready = 1'b1;
    cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid) cnt++;
    end
    chk("no_stale_after_reset", 64'(cnt), 64'd0);

    // Double-precision instance: 1.0 + 2.0
    @(posedge clk);
    #1;
    d_in_a = 64'h3FF0000000000000; d_in_b = 64'h4000000000000000;
    d_in_sub = 1'b0; d_in_tag = 4'd3; d_in_valid = 1'b1;
    @(negedge clk);
    acc = d_in_ready;
    chk("dp_accept", 64'(acc), 64'd1);
    if (acc) q64.push_back(64'h4008000000000000);
    @(posedge clk);
    #1 d_in_valid = 1'b0;
    for (int n = 0; n < 20; n++) begin
      if (q64.size() == 0) break;
      @(posedge clk);
    end
    #1;
    chk("dp_drain", 64'(q64.size()), 64'd0);
    chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
